// File: rtl/bp_me_cce_req_latency_tracker.sv
// Passive latency monitor for one CCE's LCE request channel: timestamps accepted requests in an
// in-order queue and emits per-request latency samples. Optional min/max tracking: BP_ME_CCE_LAT_MINMAX_EN.
module bp_me_cce_req_latency_tracker #(
  parameter int hdr_width_p = 64,
  parameter int els_p       = 4,
  parameter int cnt_width_p = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [hdr_width_p-1:0]       lce_req_header_i,
  input  logic                         lce_req_v_i,
  input  logic                         lce_req_ready_and_i,
  input  logic                         done_i,
  output logic                         start_o,
  output logic [hdr_width_p-1:0]       start_header_o,
  output logic                         end_o,
  output logic                         lat_v_o,
  output logic [cnt_width_p-1:0]       lat_o,
  output logic [hdr_width_p-1:0]       lat_header_o,
  output logic [$clog2(els_p+1)-1:0]   outstanding_o,
  output logic                         overflow_o,
`ifdef BP_ME_CCE_LAT_MINMAX_EN
  output logic [cnt_width_p-1:0]       lat_min_o,
  output logic [cnt_width_p-1:0]       lat_max_o,
`endif
  output logic                         underflow_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int occ_w_lp = $clog2(els_p+1);
  localparam logic [occ_w_lp-1:0] full_occ_lp = occ_w_lp'(els_p);
  localparam logic [occ_w_lp-1:0] one_occ_lp  = occ_w_lp'(1);

  logic [cnt_width_p-1:0] ts_r;
  logic [hdr_width_p-1:0] hdr_mem [els_p];
  logic [cnt_width_p-1:0] ts_mem  [els_p];
  logic [ptr_w_lp-1:0]    rd_ptr_r, wr_ptr_r;
  logic [occ_w_lp-1:0]    occ_r, occ_n;

  logic accept, empty, full, last, push, pop;
  logic [cnt_width_p-1:0] lat_n;

  always_comb begin
    accept = lce_req_v_i & lce_req_ready_and_i;
    empty  = (occ_r == '0);
    full   = (occ_r == full_occ_lp);
    last   = (occ_r == one_occ_lp);
    pop    = done_i & ~empty;
    // A full queue still takes a push when the head retires in the same cycle.
    push   = accept & (~full | pop);
    lat_n  = ts_r - ts_mem[rd_ptr_r];
    occ_n  = occ_r;
    if (push & ~pop)      occ_n = occ_r + one_occ_lp;
    else if (pop & ~push) occ_n = occ_r - one_occ_lp;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      hdr_mem[wr_ptr_r] <= lce_req_header_i;
      ts_mem[wr_ptr_r]  <= ts_r;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ts_r           <= '0;
      rd_ptr_r       <= '0;
      wr_ptr_r       <= '0;
      occ_r          <= '0;
      start_o        <= 1'b0;
      start_header_o <= '0;
      end_o          <= 1'b0;
      lat_v_o        <= 1'b0;
      lat_o          <= '0;
      lat_header_o   <= '0;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      ts_r    <= ts_r + 1'b1;
      occ_r   <= occ_n;
      lat_v_o <= pop;
      start_o <= push & (empty | (last & pop));
      end_o   <= pop & last & ~push;
      if (push) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
        if (empty | (last & pop)) start_header_o <= lce_req_header_i;
      end
      if (pop) begin
        rd_ptr_r     <= rd_ptr_r + 1'b1;
        lat_o        <= lat_n;
        lat_header_o <= hdr_mem[rd_ptr_r];
      end
      if (accept & full & ~pop) overflow_o  <= 1'b1;
      if (done_i & empty)       underflow_o <= 1'b1;
    end
  end

  assign outstanding_o = occ_r;

`ifdef BP_ME_CCE_LAT_MINMAX_EN
  logic seen_r;
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      seen_r    <= 1'b0;
      lat_min_o <= '1;
      lat_max_o <= '0;
    end else if (pop) begin
      seen_r <= 1'b1;
      if (!seen_r || lat_n < lat_min_o) lat_min_o <= lat_n;
      if (!seen_r || lat_n > lat_max_o) lat_max_o <= lat_n;
    end
  end
`endif

endmodule
